// File: rtl/up5bit_counter_pkg.sv
// Shared constants and helpers for the dual up-counter block.
package up5bit_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 5;

    // Terminal-count pattern for a counter of the given width (width <= 16).
    function automatic logic [15:0] all_ones(input int unsigned width);
        return 16'((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/up5bit_counter_dual_if.sv
// Bundle of the tick strobe and the two counter outputs/terminal counts.
interface up5bit_counter_dual_if #(
    parameter int unsigned WIDTH = up5bit_counter_pkg::DEFAULT_WIDTH
) ();

    logic             tick1;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             tc0;
    logic             tc1;

    modport master (
        output tick1,
        input  out0,
        input  out1,
        input  tc0,
        input  tc1
    );

    modport slave (
        input  tick1,
        output out0,
        output out1,
        output tc0,
        output tc1
    );

endinterface

// File: rtl/up5bit_counter_dual_up_counter.sv
// Enabled WIDTH-bit up-counter with async active-high reset and wrap pulse.
module up_counter
    import up5bit_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Gated by rst so the pulse drops the instant reset asserts.
    always_comb begin
        q  = q_q;
        tc = (q_q == MaxCount) & en & ~rst;
    end

endmodule

// File: rtl/up5bit_counter_dual.sv
// Two independent up-counters: counter 0 every clk0, counter 1 on tick1 advances.
// Define TICK1_SYNC_EDGE_EN to treat tick1 as an async level (sync + rising-edge detect).
module up5bit_counter_dual
    import up5bit_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk0,
    input  logic                       reset,
    up5bit_counter_dual_if.slave       bus
);

    logic adv1;

`ifdef TICK1_SYNC_EDGE_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = bus.tick1;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    // One advance per synchronized rising edge of tick1.
    assign adv1 = sync2_q & ~hist_q;
`else
    assign adv1 = bus.tick1;
`endif

    up_counter #(
        .WIDTH (WIDTH)
    ) u_cnt0 (
        .clk (clk0),
        .rst (reset),
        .en  (1'b1),
        .q   (bus.out0),
        .tc  (bus.tc0)
    );

    up_counter #(
        .WIDTH (WIDTH)
    ) u_cnt1 (
        .clk (clk0),
        .rst (reset),
        .en  (adv1),
        .q   (bus.out1),
        .tc  (bus.tc1)
    );

endmodule

// File: tb/tb_up5bit_counter_dual.sv
// Scoreboard bench for up5bit_counter_dual; follows TICK1_SYNC_EDGE_EN if defined.
module tb_up5bit_counter_dual;

    localparam int unsigned W = 5;
    localparam logic [W-1:0] MaxV = 5'd31;

    typedef struct {
        int          cyc;
        bit          full;   // compare tc flags too (model items) vs counts only (hand items)
        string       name;
        logic [W-1:0] o0;
        logic [W-1:0] o1;
        logic        t0;
        logic        t1;
    } item_t;

    logic clk0 = 1'b0;
    logic reset;

    up5bit_counter_dual_if #(.WIDTH(W)) bus ();

    up5bit_counter_dual #(
        .WIDTH (W)
    ) dut (
        .clk0  (clk0),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk0 = ~clk0;

    item_t        sb_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    int           cyc    = 0;
    int           cur_cyc = -1;
    string        phase  = "init";

    // Bench-side reference state.
    logic [W-1:0] m0, m1;
    logic         ms1, ms2, mh;

    // Monitor: compare everything scheduled for the current cycle at mid-cycle.
    always @(negedge clk0) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cur_cyc) begin
            item_t it;
            it = sb_q.pop_front();
            n_cmp++;
            if (it.cyc < cur_cyc) begin
                n_fail++;
                $display("FAIL %s cyc%0d: stale expectation, never sampled", it.name, it.cyc);
            end else if (bus.out0 !== it.o0 || bus.out1 !== it.o1 ||
                         (it.full && (bus.tc0 !== it.t0 || bus.tc1 !== it.t1))) begin
                n_fail++;
                $display("FAIL %s cyc%0d: got out0=%0d out1=%0d tc0=%b tc1=%b, want out0=%0d out1=%0d tc0=%b tc1=%b%s",
                         it.name, it.cyc, bus.out0, bus.out1, bus.tc0, bus.tc1,
                         it.o0, it.o1, it.t0, it.t1, it.full ? "" : " (tc ignored)");
            end
        end
    end

    // One clock cycle: drive inputs, queue the model expectation, advance the model.
    task automatic step(input logic r, input logic t, input bit late);
        item_t it;
        logic  adv;
        cur_cyc = cyc;
        bus.tick1 = t;
        if (late) #2;
        reset = r;
`ifdef TICK1_SYNC_EDGE_EN
        adv = ms2 & ~mh;
`else
        adv = t;
`endif
        it.cyc  = cyc;
        it.full = 1'b1;
        it.name = phase;
        it.o0   = r ? '0 : m0;
        it.o1   = r ? '0 : m1;
        it.t0   = ~r & (m0 == MaxV);
        it.t1   = ~r & (m1 == MaxV) & adv;
        sb_q.push_back(it);
        if (r) begin
            m0 = '0; m1 = '0; ms1 = 1'b0; ms2 = 1'b0; mh = 1'b0;
        end else begin
            m0 = m0 + 1'b1;
            if (adv) m1 = m1 + 1'b1;
            mh  = ms2;
            ms2 = ms1;
            ms1 = t;
        end
        @(posedge clk0);
        #1;
        cyc++;
    endtask

    // Hand-computed counts for the next step's sample.
    task automatic expect_hand(input string nm, input logic [W-1:0] e0, input logic [W-1:0] e1);
        item_t it;
        it.cyc  = cyc;
        it.full = 1'b0;
        it.name = nm;
        it.o0   = e0;
        it.o1   = e1;
        it.t0   = 1'b0;
        it.t1   = 1'b0;
        sb_q.push_back(it);
    endtask

    initial begin
        reset = 1'b1;
        bus.tick1 = 1'b1;
        m0 = '0; m1 = '0; ms1 = 1'b0; ms2 = 1'b0; mh = 1'b0;
        @(posedge clk0);
        #1;

        phase = "reset_hold";
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);

        phase = "cnt0_run";
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b0);
        expect_hand("cnt0_wrap", 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b0);

        phase = "tick_high";
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0);
`ifndef TICK1_SYNC_EDGE_EN
        expect_hand("tick_high_wrap", 5'd0, 5'd0);
`else
        expect_hand("tick_high_once", 5'd0, 5'd1);
`endif
        step(1'b0, 1'b0, 1'b0);

        phase = "tick_toggle";
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, (i % 2) == 0, 1'b0);
`ifndef TICK1_SYNC_EDGE_EN
        expect_hand("toggle_counts", 5'd20, 5'd10);
`endif
        step(1'b0, 1'b0, 1'b0);

        phase = "async_reset";
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0);
        expect_hand("async_clear", 5'd0, 5'd0);
        step(1'b1, 1'b1, 1'b1);
        expect_hand("release_first", 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

`ifdef TICK1_SYNC_EDGE_EN
        phase = "square8";
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b0, (i % 8) < 4, 1'b0);
        expect_hand("square8_count", 5'd0, 5'd8);
        step(1'b0, 1'b0, 1'b0);
`endif

        // Drain: everything queued should already have been sampled.
        repeat (3) @(negedge clk0);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
